// File: rtl/fifo.sv
// fifo: single-clock synchronous FIFO with a registered read port.
// Parameters: WIDTH data bits per word, DEPTH entries (power of two, >= 2).
// Ports: clk; rst (async, active-low); wdata/wr_en write side; rdata/rd_en read side;
//        full_flag/empty_flag decoded from the registered occupancy count;
//        overflow/underflow sticky error flags only when FIFO_ERR_EN is defined.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wr_en,
  output logic             full_flag,
  output logic [WIDTH-1:0] rdata,
  input  logic             rd_en,
  output logic             empty_flag
`ifdef FIFO_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             wr_ok, rd_ok;
  assign full_flag  = count_q == (AW+1)'(DEPTH);
  assign empty_flag = count_q == '0;
  assign rdata      = rdata_q;
  // A full FIFO blocks the write even if a read is accepted on the same edge.
  assign wr_ok = wr_en & ~full_flag;
  assign rd_ok = rd_en & ~empty_flag;
  always_comb begin
    wptr_d  = wr_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = rd_ok ? rptr_q + 1'b1 : rptr_q;
    rdata_d = rd_ok ? mem_q[rptr_q] : rdata_q;
    count_d = (wr_ok && !rd_ok) ? count_q + 1'b1 :
              (rd_ok && !wr_ok) ? count_q - 1'b1 : count_q;
  end
  // Storage is not reset; stale entries become unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= wdata;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
    end
  end
`ifdef FIFO_ERR_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  always_comb begin
    overflow_d  = overflow_q | (wr_en & full_flag & ~rd_ok);
    underflow_d = underflow_q | (rd_en & empty_flag);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
`endif
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed self-checking bench for fifo (WIDTH=32, DEPTH=16).
module tb_fifo;
  logic        clk, rst, wr_en, rd_en, full_flag, empty_flag;
  logic [31:0] wdata, rdata;
  int          n_cmp, n_err;
`ifdef FIFO_ERR_EN
  logic        overflow, underflow;
`endif

  fifo #(.WIDTH(32), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .wr_en(wr_en), .full_flag(full_flag),
    .rdata(rdata), .rd_en(rd_en), .empty_flag(empty_flag)
`ifdef FIFO_ERR_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = '0;
    rst   = 1'b1;
    #1 rst = 1'b0;
    #3;
    check("reset_empty", 32'(empty_flag), 32'd1);
    check("reset_full", 32'(full_flag), 32'd0);
    check("reset_rdata", rdata, 32'd0);
`ifdef FIFO_ERR_EN
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_underflow", 32'(underflow), 32'd0);
`endif
    tick();
    rst = 1'b1;
    // Fill with 0..15
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata = 32'(i);
      tick();
      if (i == 0) check("fill_empty_falls", 32'(empty_flag), 32'd0);
      if (i == 14) check("fill_not_full_15", 32'(full_flag), 32'd0);
    end
    check("fill_full", 32'(full_flag), 32'd1);
    // Write while full is dropped
    wdata = 32'd99;
    tick();
    wr_en = 1'b0;
    check("ovf_full_stays", 32'(full_flag), 32'd1);
`ifdef FIFO_ERR_EN
    check("ovf_sticky", 32'(overflow), 32'd1);
`endif
    // Drain 0..15, then one read while empty
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("drain_rdata", rdata, 32'(i));
    end
    check("drain_empty", 32'(empty_flag), 32'd1);
    check("drain_not_full", 32'(full_flag), 32'd0);
    tick();
    rd_en = 1'b0;
    check("udf_rdata_hold", rdata, 32'd15);
`ifdef FIFO_ERR_EN
    check("udf_sticky", 32'(underflow), 32'd1);
`endif
    // 20 writes with continuous reads after the first; crosses pointer wrap
    wr_en = 1'b1;
    wdata = 32'd100;
    tick();
    check("wrap_first_empty", 32'(empty_flag), 32'd0);
    rd_en = 1'b1;
    for (int k = 1; k < 20; k++) begin
      wdata = 32'(100 + k);
      tick();
      check("wrap_rdata", rdata, 32'(100 + k - 1));
      check("wrap_flags", {30'd0, empty_flag, full_flag}, 32'd0);
    end
    wr_en = 1'b0;
    tick();
    rd_en = 1'b0;
    check("wrap_last_rdata", rdata, 32'd119);
    check("wrap_final_empty", 32'(empty_flag), 32'd1);
    // Reset in the middle of a burst
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata = 32'(200 + i);
      tick();
    end
    wr_en = 1'b0;
    check("mid_not_empty", 32'(empty_flag), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_empty", 32'(empty_flag), 32'd1);
    check("mid_rst_full", 32'(full_flag), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    rst = 1'b1;
    wr_en = 1'b1;
    wdata = 32'd99;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("post_rst_rdata", rdata, 32'd99);
    check("post_rst_empty", 32'(empty_flag), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo.md
# fifo

Synchronous single-clock first-in first-out buffer of `DEPTH` words of `WIDTH` bits. It provides write/read enables with full and empty status. It is the buffering element between the packet parser and the DMA engine, and is usable anywhere a same-clock elastic buffer is needed. Reads are registered: data appears on `rdata` one clock edge after an accepted read.

## Interface
- `WIDTH`, 32, data word width in bits (≥1).
- `DEPTH`, 16, number of storage entries; power of two, ≥2.

- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous and active-low; `rst`=0 clears all state immediately.
- `wdata`  input  WIDTH  write data, sampled at rising `clk` when a write is accepted.
- `wr_en`  input  1  write request.
- `full_flag`  output  1  high when DEPTH words are stored.
- `rdata`  output  WIDTH  read data register.
- `rd_en`  input  1  read request.
- `empty_flag`  output  1  high when zero words are stored.
- `overflow`  output  1  sticky write-while-full error (only with `FIFO_ERR_EN`).
- `underflow`  output  1  sticky read-while-empty error (only with `FIFO_ERR_EN`).

## Operation
- Storage: DEPTH×WIDTH array with write pointer, read pointer (each log2(DEPTH) bits) and occupancy count (log2(DEPTH)+1 bits).
- Write accepted iff `wr_en`=1 and `full_flag`=0. On acceptance, `mem[wptr]`←`wdata` and `wptr`←`wptr`+1.
- Read accepted iff `rd_en`=1 and `empty_flag`=0. On acceptance, `rdata`←`mem[rptr]` and `rptr`←`rptr`+1.
- Pointers wrap modulo DEPTH naturally, with no extra logic; entry DEPTH-1 is followed by entry 0.
- Count update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on both or neither.
- `full_flag` = (count == DEPTH). `empty_flag` = (count == 0). Both are decoded from registered count; there are no combinational paths from the enables.
- Write while full: ignored. Memory, pointers and count are unchanged.
- Read while empty: ignored. `rdata` holds its previous value.
- Simultaneous read and write:
  - Neither flag set: both occur; count is unchanged.
  - Empty: only the write occurs.
  - Full: only the read occurs; the write is dropped.
- `rdata` holds its last value whenever no read is accepted.
- Reset (`rst`=0, any time, including mid-burst):
  - `wptr`=0, `rptr`=0, count=0, `rdata`=0.
  - `empty_flag`=1, `full_flag`=0.
  - Memory contents are not cleared and are unreachable after reset.

## Timing
- Reset values: `rdata`=0, `empty_flag`=1, `full_flag`=0, `overflow`=0, `underflow`=0.
- Write-to-flag latency: one edge. After the first accepted write, `empty_flag` falls after that edge.
- After the DEPTH-th accepted write, `full_flag` rises after that edge.
- Read latency: one edge. The word is valid on `rdata` after the edge that accepts the read.
- Write-to-read latency: a word written at edge N is readable by a read accepted at edge N+1 or later.
- Enables are level-sensitive. Each cycle with an accepted enable transfers exactly one word.
- Reset deassertion is synchronized by the integrator. The block resumes at the first rising edge with `rst`=1.

## Configuration
- Macro `FIFO_ERR_EN`.
- Defined:
  - `overflow` and `underflow` ports exist.
  - `overflow` sets on any edge with `wr_en`=1 and `full_flag`=1, unless a read is accepted on the same edge.
  - `underflow` sets on any edge with `rd_en`=1 and `empty_flag`=1.
  - Both are sticky until reset.
- Undefined: ports and logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset: drive `rst`=0 for 5 ns -> `empty_flag`=1, `full_flag`=0, `rdata`=0 immediately, with no clock edge needed.
- Fill: write 0..15 on 16 consecutive edges -> `empty_flag`=0 after the first edge; `full_flag`=1 after the 16th edge.
- Overflow: with the FIFO full, write 99 -> contents unchanged, `full_flag` stays 1, and `overflow`=1 when `FIFO_ERR_EN` is defined.
- Drain: assert `rd_en` for 16 edges -> `rdata` sequence 0,1,…,15, each one edge after its read.
  - `empty_flag`=1 after the 16th read.
  - A 17th read leaves `rdata`=15 and sets `underflow` (with `FIFO_ERR_EN` defined).
- Wrap and simultaneous operation:
  - Write 20 words while reading continuously after the first write -> data order is preserved across pointer wrap.
  - Count stays 1, with no flag asserted.
- Reset mid-operation: after 5 writes, assert reset, then write 99 and read once -> `rdata`=99 and `empty_flag`=1 afterwards.
